// File: rtl/capture_sequencer.sv
// Frame-capture sequencer: erase, expose for a clamped exposure length, then read rows 1 and 2.
// Outputs are registered from the next state, so they change on the same edge as the state.
module capture_sequencer #(
  parameter int ERASE_CYCLES = 2,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic [4:0] Exp_Time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Busy,
  output logic       Frame_Done
);

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, READ_1, READ_2, DONE} state_t;

  localparam logic [4:0] ERASE_LOAD = 5'(ERASE_CYCLES - 1);
  localparam logic [4:0] E_MIN      = 5'(EXP_MIN);
  localparam logic [4:0] E_MAX      = 5'(EXP_MAX);
  localparam logic [4:0] READ_LOAD  = 5'd2;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [4:0] e_len, e_clamp;
  logic       init_q;
  logic       start;

  assign start = Init & ~init_q & (state == IDLE);

  always_comb begin
    e_clamp = Exp_Time;
    if (Exp_Time < E_MIN)
      e_clamp = E_MIN;
    else if (Exp_Time > E_MAX)
      e_clamp = E_MAX;
  end

  // Each timed phase loads the counter with (length - 1) and leaves when it reaches 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ERASE;
          cnt_nxt   = ERASE_LOAD;
        end
      end
      ERASE: begin
        if (cnt == 5'd0) begin
          state_nxt = EXPOSE;
          cnt_nxt   = e_len - 5'd1;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      EXPOSE: begin
        if (cnt == 5'd0) begin
          state_nxt = READ_1;
          cnt_nxt   = READ_LOAD;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      READ_1: begin
        if (cnt == 5'd0) begin
          state_nxt = READ_2;
          cnt_nxt   = READ_LOAD;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      READ_2: begin
        if (cnt == 5'd0) begin
          state_nxt = DONE;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  // init_q resets high so an Init held through reset is not taken as a new edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      e_len      <= 5'd0;
      init_q     <= 1'b1;
      Erase      <= 1'b0;
      Expose     <= 1'b0;
      NRE_1      <= 1'b1;
      NRE_2      <= 1'b1;
      ADC        <= 1'b0;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      init_q     <= Init;
      if (start)
        e_len <= e_clamp;
      Erase      <= (state_nxt == ERASE);
      Expose     <= (state_nxt == EXPOSE);
      NRE_1      <= (state_nxt != READ_1);
      NRE_2      <= (state_nxt != READ_2);
      ADC        <= ((state_nxt == READ_1) || (state_nxt == READ_2)) && (cnt_nxt == 5'd1);
      Busy       <= (state_nxt != IDLE);
      Frame_Done <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Frame-capture state machine for the digital camera. It takes the exposure length produced by the exposure-time controller and sequences one capture of the two-row pixel array per start request: erase, expose, then read out row 1 and row 2 through the ADC. It sits between the user start button and the pixel array/ADC control lines. It runs on the same 1 kHz system clock, so one cycle is 1 ms of exposure.

## Interface
Parameters:
- ERASE_CYCLES, 2: length of the erase phase in Clk cycles; legal range 1..7.
- EXP_MIN, 2: lower clamp for the exposure length in cycles.
- EXP_MAX, 30: upper clamp for the exposure length in cycles.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Init  in  1  capture request; only a rising edge starts a capture.
- Exp_Time  in  5  exposure length in cycles, from the exposure-time controller.
- Erase  out  1  high to erase the pixel array.
- Expose  out  1  high while the pixels integrate.
- NRE_1  out  1  active-low read enable for row 1.
- NRE_2  out  1  active-low read enable for row 2.
- ADC  out  1  single-cycle ADC convert strobe.
- Busy  out  1  high whenever the state is not IDLE.
- Frame_Done  out  1  one-cycle pulse in the DONE state.

## Operation
- States: IDLE, ERASE, EXPOSE, READ_1, READ_2, DONE.
- All outputs are Moore outputs decoded from registered state, so each output changes on the same edge as the state.
- Start detection:
  - Init_q holds Init delayed by one cycle.
  - start = Init & ~Init_q & (state == IDLE).
  - A rising edge seen in any other state is discarded, not queued.
  - Init held high starts exactly one capture.
- On start:
  - E = clamp(Exp_Time, EXP_MIN, EXP_MAX) is latched.
  - Exp_Time changes after that edge have no effect on the current capture.
  - State goes to ERASE.
- ERASE: Erase=1 for ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: Expose=1 for exactly E cycles, using a 5-bit down-counter loaded with E-1; at 0 go to READ_1.
- READ_1: 3 cycles. NRE_1=0 on all three, ADC=1 on the second only, then READ_2.
- READ_2: same as READ_1 but on NRE_2, then DONE.
- DONE: 1 cycle. Frame_Done=1, then IDLE.
- Busy=1 in every state except IDLE.
- Only one of Erase, Expose, NRE_1=0 and NRE_2=0 is ever active at a time.
- Idle output values: Erase=0, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Frame_Done=0, Busy=0.

## Timing
- Reset is synchronous and has priority over everything else.
- Reset values:
  - State becomes IDLE and all outputs take their idle values the cycle after Reset is sampled.
  - Counters clear to 0.
  - Init_q is set to 1, so Init held high through reset does not start a capture; Init must go low and then high again.
- Reset mid-capture aborts immediately. No Frame_Done is generated and no further ADC strobes occur.
- Latency, with the rising edge of Init sampled at edge 0:
  - ERASE covers cycles 1..ERASE_CYCLES.
  - EXPOSE covers the next E cycles.
  - READ_1 and READ_2 cover 3 cycles each.
  - DONE covers 1 cycle.
  - IDLE is reached at cycle ERASE_CYCLES+E+8.
- Busy length is ERASE_CYCLES+E+7 cycles.
- The earliest accepted next start is a rising edge sampled in the first IDLE cycle. That needs Init low in some cycle before it.
- Clamping:
  - Exp_Time 0 or 1 gives E=2.
  - Exp_Time 31 gives E=30.
  - Exp_Time 2..30 is used unchanged.
- The comparison is 5-bit unsigned; there is no wrap-around.

## Test plan
- Normal capture, ERASE_CYCLES=2, Exp_Time=5, Init pulsed (edge sampled at 0):
  - Erase high on cycles 1-2 and Expose on 3-7.
  - NRE_1 low on 8-10 with ADC on 9; NRE_2 low on 11-13 with ADC on 12.
  - Frame_Done on 14, Busy on 1-14, IDLE at 15.
- Clamping:
  - Exp_Time=0 gives Expose high for exactly 2 cycles.
  - Exp_Time=31 gives exactly 30 cycles.
  - Exp_Time=17 gives 17 cycles.
- Init held high for 40 cycles: exactly one capture and one Frame_Done. Then Init low for 1 cycle and high again: a second capture starts.
- Init re-pulsed during EXPOSE and again during READ_2: no effect. Exactly 2 ADC strobes and 1 Frame_Done.
- Exp_Time changed 5→20 in the middle of EXPOSE: Expose still lasts 5 cycles.
- Reset asserted on the 3rd EXPOSE cycle:
  - The next cycle shows all idle values and Busy=0.
  - No ADC strobe and no Frame_Done follow.
  - A new Init edge then runs a full capture.
